// File: rtl/contador_uns_sequencial.sv
// ----------------------------------------------------------------------------
// contador_uns_sequencial
//
// Sequential ones-counter. Each accepted LARGURA-bit word is counted FATIA bits
// per clock, lowest slice first. Counts from every word in a packet are added
// into one saturating accumulator. The last word of the packet is marked by
// `ultimo`. After the last word is counted, the packet total, a threshold flag
// and a sticky saturation flag are presented on a valid/ready handshake.
//
// Parameters
//   LARGURA : input word width
//   FATIA   : bits counted per clock. It must divide LARGURA.
//             K = LARGURA/FATIA counting cycles per word.
//   ACUM_W  : width of the accumulator, of total and of limiar
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; drops any packet in flight
//   entrada_valida input word valid
//   entrada_pronta ready to accept a word; decoded from registered state only
//   chaves         word whose set bits are counted
//   ultimo         accepted word is the last of its packet
//   limiar         threshold, sampled in the last counting cycle of a packet
//   saida_valida   total and flags valid
//   saida_pronta   downstream accepts the total
//   total          saturating ones-count of the packet
//   acima_limiar   total >= limiar
//   saturou        accumulator saturated during this packet
// ----------------------------------------------------------------------------
module contador_uns_sequencial #(
  parameter int LARGURA = 8,
  parameter int FATIA   = 2,
  parameter int ACUM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entrada_valida,
  output logic              entrada_pronta,
  input  logic [LARGURA-1:0] chaves,
  input  logic              ultimo,
  input  logic [ACUM_W-1:0] limiar,
  output logic              saida_valida,
  input  logic              saida_pronta,
  output logic [ACUM_W-1:0] total,
  output logic              acima_limiar,
  output logic              saturou
);

  localparam int K     = LARGURA / FATIA;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int POP_W = $clog2(FATIA + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    CONTANDO,
    APRESENTA
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox_estado;
  logic [LARGURA-1:0]  r_shift;
  logic [CNT_W-1:0]    r_fatia_cnt;
  logic                r_ultimo;
  logic [ACUM_W-1:0]   r_acum;
  logic                r_sat;       // sticky: set by any clamp within the packet
  logic [ACUM_W-1:0]   r_total;
  logic                r_acima;
  logic                r_saturou;

  logic [POP_W-1:0]    w_pop;
  logic [ACUM_W:0]     w_soma;
  logic                w_estouro;
  logic [ACUM_W-1:0]   w_acum_prox;
  logic                w_ultima_fatia;

  // Popcount of the slice currently at the bottom of the shift register.
  // NOTE: every variable written in always_comb gets a default value first.
  // Without it, a path that skips the assignment would infer a latch.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < FATIA; b++) begin
      w_pop = w_pop + POP_W'(r_shift[b]);
    end
  end

  // One extra bit catches the carry. On overflow the value clamps to all-ones
  // instead of wrapping.
  assign w_soma         = {1'b0, r_acum} + (ACUM_W + 1)'(w_pop);
  assign w_estouro      = w_soma[ACUM_W];
  assign w_acum_prox    = w_estouro ? {ACUM_W{1'b1}} : w_soma[ACUM_W-1:0];
  assign w_ultima_fatia = (r_fatia_cnt == CNT_W'(K - 1));

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:    if (entrada_valida) w_prox_estado = CONTANDO;
      CONTANDO:  if (w_ultima_fatia) w_prox_estado = r_ultimo ? APRESENTA : OCIOSO;
      APRESENTA: if (saida_pronta)   w_prox_estado = OCIOSO;
      default:   w_prox_estado = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, and the order of statements does not
  // matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_shift     <= '0;
      r_fatia_cnt <= '0;
      r_ultimo    <= 1'b0;
      r_acum      <= '0;
      r_sat       <= 1'b0;
      r_total     <= '0;
      r_acima     <= 1'b0;
      r_saturou   <= 1'b0;
    end else begin
      r_estado <= w_prox_estado;
      case (r_estado)
        OCIOSO: begin
          if (entrada_valida) begin
            r_shift     <= chaves;
            r_ultimo    <= ultimo;
            r_fatia_cnt <= '0;
          end
        end
        CONTANDO: begin
          r_acum      <= w_acum_prox;
          r_sat       <= r_sat | w_estouro;
          r_shift     <= r_shift >> FATIA;
          r_fatia_cnt <= r_fatia_cnt + CNT_W'(1);
          // Register the results from the post-add value, so the final slice
          // is included. limiar is compared in this same cycle.
          if (w_ultima_fatia && r_ultimo) begin
            r_total   <= w_acum_prox;
            r_acima   <= (w_acum_prox >= limiar);
            r_saturou <= r_sat | w_estouro;
          end
        end
        APRESENTA: begin
          if (saida_pronta) begin
            r_acum    <= '0;
            r_sat     <= 1'b0;
            r_saturou <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign entrada_pronta = (r_estado == OCIOSO);
  assign saida_valida   = (r_estado == APRESENTA);
  assign total          = r_total;
  assign acima_limiar   = r_acima;
  assign saturou        = r_saturou;

endmodule

// File: tb/tb_contador_uns_sequencial.sv
// ----------------------------------------------------------------------------
// tb_contador_uns_sequencial
//
// Four instances share one clock:
//   unit 0: defaults (8/2/16)
//   unit 1: ACUM_W=4, to exercise saturation
//   unit 2: LARGURA=16, FATIA=4
//   unit 3: FATIA=LARGURA=8, so each word takes a single counting cycle
// The driver issues directed words. For each packet it pushes the
// hand-computed result into that unit's queue. The monitor pops a result at
// each output handshake and compares it against the front entry.
// ----------------------------------------------------------------------------
module tb_contador_uns_sequencial;

  typedef struct {
    logic [15:0] total;
    logic        acima;
    logic        sat;
    int          acc;     // number of the edge that accepted the last word
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0]       rst, v_in, ult, sp;
  logic [3:0][15:0] chv, lim;
  logic [3:0]       rdy, sv, acima, sat;
  logic [15:0]      tot0, tot2, tot3;
  logic [3:0]       tot1;
  wire  [3:0][15:0] tot = {tot3, tot2, {12'd0, tot1}, tot0};

  exp_t q [4][$];
  bit [3:0] prev_sv = '0;
  bit [3:0] post    = '0;
  exp_t     m_e;

  contador_uns_sequencial u_main (
    .clk(clk), .reset(rst[0]), .entrada_valida(v_in[0]), .entrada_pronta(rdy[0]),
    .chaves(chv[0][7:0]), .ultimo(ult[0]), .limiar(lim[0]), .saida_valida(sv[0]),
    .saida_pronta(sp[0]), .total(tot0), .acima_limiar(acima[0]), .saturou(sat[0]));

  contador_uns_sequencial #(.ACUM_W(4)) u_sat (
    .clk(clk), .reset(rst[1]), .entrada_valida(v_in[1]), .entrada_pronta(rdy[1]),
    .chaves(chv[1][7:0]), .ultimo(ult[1]), .limiar(lim[1][3:0]), .saida_valida(sv[1]),
    .saida_pronta(sp[1]), .total(tot1), .acima_limiar(acima[1]), .saturou(sat[1]));

  contador_uns_sequencial #(.LARGURA(16), .FATIA(4)) u_wide (
    .clk(clk), .reset(rst[2]), .entrada_valida(v_in[2]), .entrada_pronta(rdy[2]),
    .chaves(chv[2]), .ultimo(ult[2]), .limiar(lim[2]), .saida_valida(sv[2]),
    .saida_pronta(sp[2]), .total(tot2), .acima_limiar(acima[2]), .saturou(sat[2]));

  contador_uns_sequencial #(.FATIA(8)) u_f8 (
    .clk(clk), .reset(rst[3]), .entrada_valida(v_in[3]), .entrada_pronta(rdy[3]),
    .chaves(chv[3][7:0]), .ultimo(ult[3]), .limiar(lim[3]), .saida_valida(sv[3]),
    .saida_pronta(sp[3]), .total(tot3), .acima_limiar(acima[3]), .saturou(sat[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int k_of(input int i);
    return (i == 3) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    check($sformatf("u%0d %s total", i, tag), tot[i], 0);
    check($sformatf("u%0d %s saida_valida", i, tag), sv[i], 0);
    check($sformatf("u%0d %s acima", i, tag), acima[i], 0);
    check($sformatf("u%0d %s saturou", i, tag), sat[i], 0);
    check($sformatf("u%0d %s entrada_pronta", i, tag), rdy[i], 1);
  endtask

  // Offer one word and wait, with a bound, until it is accepted. When push is
  // set, the expected packet result goes into the scoreboard. When busy_chk is
  // set, entrada_pronta must stay low through the K counting cycles.
  task automatic send(input int i, input logic [15:0] w, input logic u, input bit push,
                      input logic [15:0] et, input logic ea, input logic es,
                      input bit busy_chk);
    int   t;
    exp_t e;
    @(negedge clk);
    chv[i] = w; ult[i] = u; v_in[i] = 1'b1;
    t = 0;
    while (!rdy[i] && t < 100) begin @(negedge clk); t++; end
    if (!rdy[i]) check($sformatf("u%0d accept timeout", i), 0, 1);
    e.total = et; e.acima = ea; e.sat = es; e.acc = cyc + 1;
    @(negedge clk);
    v_in[i] = 1'b0; chv[i] = 16'($urandom); ult[i] = 1'($urandom);
    if (push) q[i].push_back(e);
    if (busy_chk) begin
      for (int c = 0; c < k_of(i); c++) begin
        check($sformatf("u%0d busy pronta", i), rdy[i], 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic drain(input int i);
    int t = 0;
    while (q[i].size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (q[i].size() != 0) check($sformatf("u%0d output timeout", i), 0, 1);
    @(negedge clk);
  endtask

  // Monitor: sample just after the falling edge, when the driver's inputs have
  // settled.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) begin
        prev_sv[i] = 1'b0;
        post[i]    = 1'b0;
      end else begin
        if (post[i]) begin
          check($sformatf("u%0d pronta after handshake", i), rdy[i], 1);
          check($sformatf("u%0d valid drop", i), sv[i], 0);
          post[i] = 1'b0;
        end
        if (sv[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("u%0d spurious saida_valida", i), sv[i], 0);
          end else begin
            m_e = q[i][0];
            if (!prev_sv[i])
              check($sformatf("u%0d latency", i), cyc - m_e.acc, k_of(i));
            check($sformatf("u%0d total", i), tot[i], m_e.total);
            check($sformatf("u%0d acima", i), acima[i], m_e.acima);
            check($sformatf("u%0d saturou", i), sat[i], m_e.sat);
            check($sformatf("u%0d pronta while presenting", i), rdy[i], 0);
            if (sp[i]) begin
              void'(q[i].pop_front());
              post[i] = 1'b1;
            end
          end
        end
        prev_sv[i] = sv[i];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish, n_err=%0d required 0", n_err);
    $fatal(1);
  end

  initial begin
    rst = 4'hF; v_in = '0; ult = '0; sp = 4'hF; chv = '0; lim = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_idle(i, "reset");
    rst = '0;

    // Unit 0: one word, 8'b1011_0110 -> 5 >= 4
    lim[0] = 16'd4;
    send(0, 16'hB6, 1'b1, 1'b1, 16'd5, 1'b1, 1'b0, 1'b1);
    drain(0);

    // Unit 0: three-word packet 0xFF, 0x00, 0x81 -> 10, limiar raised to 11 mid-packet
    lim[0] = 16'd0;
    send(0, 16'hFF, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    send(0, 16'h00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    lim[0] = 16'd11;
    send(0, 16'h81, 1'b1, 1'b1, 16'd10, 1'b0, 1'b0, 1'b1);
    drain(0);

    // Unit 0: backpressure, 0x0F -> 4, held while saida_pronta is low
    lim[0] = 16'd4;
    sp[0] = 1'b0;
    send(0, 16'h0F, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    sp[0] = 1'b1;
    drain(0);
    send(0, 16'h01, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1);
    drain(0);

    // Unit 0: reset in the 2nd counting cycle discards 0xFF; 0x03 -> 2
    send(0, 16'hFF, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_idle(0, "mid reset");
    rst[0] = 1'b0;
    lim[0] = 16'd2;
    send(0, 16'h03, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1);
    drain(0);

    // Unit 1 (ACUM_W=4): 0xFF + 0xFF clamps to 15; next packet starts clean
    lim[1] = 16'd15;
    send(1, 16'hFF, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    send(1, 16'hFF, 1'b1, 1'b1, 16'd15, 1'b1, 1'b1, 1'b1);
    drain(1);
    send(1, 16'h01, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 1'b1);
    drain(1);

    // Unit 2 (16/4): 0xF0F1 -> 9 (equal to limiar), 0xFFFF -> 16
    lim[2] = 16'd9;
    send(2, 16'hF0F1, 1'b1, 1'b1, 16'd9, 1'b1, 1'b0, 1'b1);
    drain(2);
    send(2, 16'hFFFF, 1'b1, 1'b1, 16'd16, 1'b1, 1'b0, 1'b1);
    drain(2);

    // Unit 3 (FATIA=8): 0xFF -> 8, 0x00 -> 0
    lim[3] = 16'd8;
    send(3, 16'hFF, 1'b1, 1'b1, 16'd8, 1'b1, 1'b0, 1'b1);
    drain(3);
    send(3, 16'h00, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1);
    drain(3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
